// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: data width and the
// arbiter FSM state encoding (also exported on the debug port).
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte stream bundle: per-requester valid/data/last with a
// per-requester ready returned by the arbiter.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) ();

  logic [NUM_REQ-1:0]             req_valid;
  logic [UART_DATA_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]             req_last;
  logic [NUM_REQ-1:0]             req_ready;

  modport master (output req_valid, req_data, req_last, input  req_ready);
  modport slave  (input  req_valid, req_data, req_last, output req_ready);

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward
// from i_ptr+1, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [NUM_REQ-1:0]         o_gnt_onehot,
  output logic [$clog2(NUM_REQ)-1:0] o_gnt_id,
  output logic                       o_any
);

  localparam int ID_W = $clog2(NUM_REQ);

  always_comb begin
    int   idx;
    logic found;
    // NOTE: every output and temporary gets a default before any branch,
    // otherwise paths that skip an assignment would infer a latch.
    idx          = 0;
    found        = 1'b0;
    o_gnt_onehot = '0;
    o_gnt_id     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(i_ptr) + 1 + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && i_req[ID_W'(idx)]) begin
        found                      = 1'b1;
        o_gnt_id                   = ID_W'(idx);
        o_gnt_onehot[ID_W'(idx)]   = 1'b1;
      end
    end
    o_any = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART serializer among NUM_REQ byte sources: round-robin between
// messages, grant locked to one owner until its last byte or a hold timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int HOLD_TIMEOUT = 1024,
  parameter int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  uart_tx_arbiter_if.slave       req,
  output logic [UART_DATA_W-1:0] o_tx_data,
  output logic                   o_tx_start,
  input  logic                   i_tx_busy,
  input  logic                   i_tx_done,
  output logic [ID_W-1:0]        o_grant_id,
  output logic                   o_owner_valid,
  output logic [1:0]             o_state_debug
);

  localparam int               CNT_W    = $clog2(HOLD_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_TIMEOUT - 1);

  arb_state_e       state;
  logic [ID_W-1:0]  ptr;
  logic             last_q;
  logic [CNT_W-1:0] hold_cnt;

  logic [NUM_REQ-1:0]     gnt_onehot;
  logic [ID_W-1:0]        gnt_id;
  logic                   gnt_any;
  logic [NUM_REQ-1:0]     ready;
  logic                   hold_expired;
  logic                   hold_accept;
  logic [ID_W-1:0]        cap_id;
  logic [UART_DATA_W-1:0] cap_data;
  logic                   cap_last;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .i_req        (req.req_valid),
    .i_ptr        (ptr),
    .o_gnt_onehot (gnt_onehot),
    .o_gnt_id     (gnt_id),
    .o_any        (gnt_any)
  );

  // Expiry is checked before the owner's valid, so a late byte loses the lock.
  assign hold_expired = (state == HOLD) && (hold_cnt >= CNT_LAST);
  assign hold_accept  = (state == HOLD) && !hold_expired && req.req_valid[o_grant_id];

  assign cap_id   = (state == ARB) ? gnt_id : o_grant_id;
  assign cap_data = req.req_data[int'(cap_id)*UART_DATA_W +: UART_DATA_W];
  assign cap_last = req.req_last[cap_id];

  always_comb begin
    ready = '0;
    if (i_rst_n) begin
      if (state == ARB)      ready = gnt_onehot;
      else if (hold_accept)  ready[o_grant_id] = 1'b1;
    end
  end

  assign req.req_ready   = ready;
  assign o_tx_start      = (state == START) && !i_tx_busy;
  assign o_owner_valid   = (state != ARB);
  assign o_state_debug   = state;

  // NOTE: non-blocking assignments so every register samples pre-edge values
  // regardless of statement order within the block.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ARB;
      ptr        <= ID_W'(NUM_REQ - 1);
      last_q     <= 1'b0;
      hold_cnt   <= '0;
      o_tx_data  <= '0;
      o_grant_id <= '0;
    end else begin
      case (state)
        ARB: begin
          if (gnt_any) begin
            o_tx_data  <= cap_data;
            last_q     <= cap_last;
            o_grant_id <= gnt_id;
            state      <= START;
          end
        end
        START: begin
          if (!i_tx_busy) state <= WAIT;
        end
        WAIT: begin
          if (i_tx_done) begin
            if (last_q) begin
              ptr   <= o_grant_id;
              state <= ARB;
            end else begin
              hold_cnt <= '0;
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (hold_expired) begin
            ptr   <= o_grant_id;
            state <= ARB;
          end else if (hold_accept) begin
            o_tx_data <= cap_data;
            last_q    <= cap_last;
            state     <= START;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: message-level round-robin model feeding a
// per-cycle scoreboard, plus directed checks for latency, timeout, stall, reset.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int HOLD_TIMEOUT = 8;
  localparam int SER_LEN      = 3;

  typedef struct { logic [7:0] data; bit last; } req_t;
  typedef struct { int id; logic [7:0] data; bit last; } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) rif ();

  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done    = 1'b0;
  logic       ser_busy   = 1'b0;
  logic       force_busy = 1'b0;
  logic [1:0] grant_id;
  logic       owner_valid;
  logic [1:0] state_dbg;

  assign tx_busy = ser_busy | force_busy;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .HOLD_TIMEOUT (HOLD_TIMEOUT)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .req           (rif),
    .o_tx_data     (tx_data),
    .o_tx_start    (tx_start),
    .i_tx_busy     (tx_busy),
    .i_tx_done     (tx_done),
    .o_grant_id    (grant_id),
    .o_owner_valid (owner_valid),
    .o_state_debug (state_dbg)
  );

  int   total = 0;
  int   bad   = 0;
  req_t rq[NUM_REQ][$];
  exp_t exp_q[$];
  bit   drv_en  = 1'b0;
  bit   sb_en   = 1'b0;
  int   n_start = 0;
  int   n_done  = 0;
  bit   mid_msg = 1'b0;
  int   lock_id = 0;
  bit [NUM_REQ-1:0] fired;
  int   pin_c[6] = '{0, 1, 3, 0, 1, 3};
  int   pin_m[5] = '{0, 1, 1, 1, 0};

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int k, logic [7:0] d, bit l, bit v);
    rif.req_valid[k]         = v;
    rif.req_data[k*8 +: 8]   = d;
    rif.req_last[k]          = l;
  endtask

  task automatic push(int k, logic [7:0] d, bit l);
    req_t r;
    r.data = d;
    r.last = l;
    rq[k].push_back(r);
  endtask

  function automatic int pending();
    int n = 0;
    for (int k = 0; k < NUM_REQ; k++) n += rq[k].size();
    return n;
  endfunction

  // Message-level model: whole messages in round-robin order, starting after
  // the reset pointer (NUM_REQ-1) so requester 0 has first priority.
  task automatic build_expected();
    int   ptr = NUM_REQ - 1;
    int   pos[NUM_REQ];
    int   w;
    bit   found;
    exp_t e;
    exp_q.delete();
    for (int k = 0; k < NUM_REQ; k++) pos[k] = 0;
    forever begin
      found = 1'b0;
      w     = 0;
      for (int s = 1; s <= NUM_REQ; s++) begin
        int k = (ptr + s) % NUM_REQ;
        if (!found && pos[k] < rq[k].size()) begin
          found = 1'b1;
          w     = k;
        end
      end
      if (!found) break;
      do begin
        e.id   = w;
        e.data = rq[w][pos[w]].data;
        e.last = rq[w][pos[w]].last;
        exp_q.push_back(e);
        pos[w]++;
      end while (!e.last && pos[w] < rq[w].size());
      ptr = w;
    end
  endtask

  task automatic wait_idle(string name);
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = (state_dbg == 2'd0) && !ser_busy && !tx_done && !force_busy &&
           (pending() == 0) && (exp_q.size() == 0);
    end
    check(name, ok, 1);
  endtask

  task automatic reset_dut();
    rif.req_valid = '0;
    rif.req_data  = '0;
    rif.req_last  = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_model(string name, int n_exp);
    n_start = 0;
    n_done  = 0;
    sb_en   = 1'b1;
    drv_en  = 1'b1;
    wait_idle(name);
    drv_en  = 1'b0;
    sb_en   = 1'b0;
    check({name, "_starts"}, n_start, n_exp);
    check({name, "_start_per_done"}, n_start, n_done);
  endtask

  // Serializer stand-in: busy for SER_LEN cycles after a start, then a done pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start && rst_n) begin
        @(posedge clk);
        #1 ser_busy = 1'b1;
        repeat (SER_LEN) @(posedge clk);
        #1;
        ser_busy = 1'b0;
        tx_done  = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  // Queue-driven requesters: present the head entry, pop it after a handshake.
  initial begin
    forever begin
      @(negedge clk);
      fired = rif.req_valid & rif.req_ready;
      @(posedge clk);
      #1;
      if (drv_en) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (fired[k] && rq[k].size() > 0) void'(rq[k].pop_front());
          if (rq[k].size() > 0) drive(k, rq[k][0].data, rq[k][0].last, 1'b1);
          else                  drive(k, 8'h00, 1'b0, 1'b0);
        end
      end
    end
  end

  // Compare process: invariants every cycle, scoreboard on every start pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("ready_at_most_one", $countones(rif.req_ready) <= 1, 1);
        check("ready_needs_valid", rif.req_ready & ~rif.req_valid, 0);
        if (tx_start) check("start_needs_owner", owner_valid, 1);
        if (sb_en) begin
          if (tx_done) n_done++;
          if (mid_msg) begin
            check("lock_owner_valid", owner_valid, 1);
            check("lock_grant", grant_id, lock_id);
          end
          if (tx_start) begin
            n_start++;
            check("start_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check("start_grant", grant_id, e.id);
              check("start_data", tx_data, e.data);
              mid_msg = !e.last;
              lock_id = e.id;
            end
          end
        end else begin
          mid_msg = 1'b0;
        end
      end else begin
        mid_msg = 1'b0;
      end
    end
  end

  initial begin
    bit got;
    int hold;
    logic [NUM_REQ-1:0] hold_ready;

    rif.req_valid = '0;
    rif.req_data  = '0;
    rif.req_last  = '0;

    // Reset values, with every requester asking
    #1 rst_n = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) drive(k, 8'h10 + 8'(k), 1'b1, 1'b1);
    #2;
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_grant", grant_id, 0);
    check("rst_ready", rif.req_ready, 4'b0000);
    check("rst_start", tx_start, 0);
    check("rst_owner", owner_valid, 0);
    check("rst_state", state_dbg, 0);
    reset_dut();

    // Single byte from requester 2: ready same cycle, start next cycle
    drive(2, 8'hA5, 1'b1, 1'b1);
    @(negedge clk);
    check("t1_ready", rif.req_ready, 4'b0100);
    check("t1_state_arb", state_dbg, 0);
    tick();
    drive(2, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    check("t1_start", tx_start, 1);
    check("t1_data", tx_data, 8'hA5);
    check("t1_grant", grant_id, 2);
    check("t1_owner", owner_valid, 1);
    check("t1_ready_off", rif.req_ready, 4'b0000);
    wait_idle("t1_idle");
    tick();
    drive(0, 8'h01, 1'b1, 1'b1);
    drive(3, 8'h03, 1'b1, 1'b1);
    @(negedge clk);
    check("t1_ptr_after_2", rif.req_ready, 4'b1000);
    tick();
    rif.req_valid = '0;
    wait_idle("t1_idle2");

    // Contention: 0, 1, 3 with single-byte messages
    reset_dut();
    for (int m = 0; m < 2; m++) begin
      push(0, 8'h20 + 8'(m), 1'b1);
      push(1, 8'h30 + 8'(m), 1'b1);
      push(3, 8'h50 + 8'(m), 1'b1);
    end
    build_expected();
    check("pin_c_len", exp_q.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < exp_q.size()) check("pin_c_id", exp_q[i].id, pin_c[i]);
    run_model("t2", 6);

    // Message lock: requester 1's three bytes go out back to back
    reset_dut();
    push(0, 8'h11, 1'b1);
    push(0, 8'h22, 1'b1);
    push(1, 8'hB1, 1'b0);
    push(1, 8'hB2, 1'b0);
    push(1, 8'hB3, 1'b1);
    build_expected();
    check("pin_m_len", exp_q.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < exp_q.size()) check("pin_m_id", exp_q[i].id, pin_m[i]);
    run_model("t3", 5);

    // Hold timeout: owner 1 stops mid-message, requester 2 waits
    reset_dut();
    drive(1, 8'h3C, 1'b0, 1'b1);
    @(negedge clk);
    check("t4_ready", rif.req_ready, 4'b0010);
    tick();
    drive(1, 8'h00, 1'b0, 1'b0);
    drive(2, 8'h77, 1'b1, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = tx_done;
    end
    check("t4_done_seen", got, 1);
    hold       = 0;
    hold_ready = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (state_dbg != 2'd3) break;
      hold++;
      hold_ready |= rif.req_ready;
    end
    check("t4_hold_cycles", hold, 8);
    check("t4_hold_no_ready", hold_ready, 4'b0000);
    check("t4_back_to_arb", state_dbg, 0);
    check("t4_next_grant", rif.req_ready, 4'b0100);
    tick();
    drive(2, 8'h00, 1'b0, 1'b0);
    wait_idle("t4_idle");

    // Owner valid rises in the cycle the timeout expires: timeout wins
    tick();
    drive(3, 8'h9E, 1'b0, 1'b1);
    @(negedge clk);
    check("t5_ready", rif.req_ready, 4'b1000);
    tick();
    drive(3, 8'h00, 1'b0, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = tx_done;
    end
    check("t5_done_seen", got, 1);
    tick();
    repeat (HOLD_TIMEOUT - 1) tick();
    drive(3, 8'h99, 1'b1, 1'b1);
    @(negedge clk);
    check("t5_still_hold", state_dbg, 3);
    check("t5_timeout_wins", rif.req_ready, 4'b0000);
    @(negedge clk);
    check("t5_arb", state_dbg, 0);
    check("t5_regrant", rif.req_ready, 4'b1000);
    tick();
    drive(3, 8'h00, 1'b0, 1'b0);
    wait_idle("t5_idle");

    // Busy stall in START
    reset_dut();
    force_busy = 1'b1;
    drive(0, 8'h5A, 1'b1, 1'b1);
    @(negedge clk);
    check("t6_ready", rif.req_ready, 4'b0001);
    tick();
    drive(0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t6_no_start", tx_start, 0);
      check("t6_data_stable", tx_data, 8'h5A);
      check("t6_in_start", state_dbg, 1);
    end
    tick();
    force_busy = 1'b0;
    @(negedge clk);
    check("t6_start", tx_start, 1);
    check("t6_start_data", tx_data, 8'h5A);
    @(negedge clk);
    check("t6_single_pulse", tx_start, 0);
    wait_idle("t6_idle");

    // Asynchronous reset while waiting for the serializer
    reset_dut();
    drive(1, 8'h42, 1'b1, 1'b1);
    tick();
    drive(1, 8'h00, 1'b0, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (state_dbg == 2'd2);
    end
    check("t7_in_wait", got, 1);
    #2;
    for (int k = 0; k < NUM_REQ; k++) drive(k, 8'hC0 + 8'(k), 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t7_rst_tx_data", tx_data, 8'h00);
    check("t7_rst_grant", grant_id, 0);
    check("t7_rst_ready", rif.req_ready, 4'b0000);
    check("t7_rst_start", tx_start, 0);
    check("t7_rst_owner", owner_valid, 0);
    check("t7_rst_state", state_dbg, 0);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = !ser_busy && !tx_done;
    end
    check("t7_ser_drained", got, 1);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("t7_first_grant", rif.req_ready, 4'b0001);
    tick();
    rif.req_valid = '0;
    wait_idle("t7_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
